// File: rtl/dcache_snoop_responder.sv
// Cache-side MSI snoop responder: looks up the snooped block, flushes both words of a
// Modified hit to the coherence controller, then downgrades/invalidates the frame and LL link.
module dcache_snoop_responder #(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  parameter int IDXW = $clog2(SETS),
  parameter int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1,
  parameter int TAGW = 32 - 3 - IDXW
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ccwait,
  input  logic                 ccinv,
  input  logic [31:0]          ccsnoopaddr,
  input  logic                 dwait,
  output logic                 ccwrite,
  output logic [31:0]          snoop_dstore,
  output logic                 snoop_active,
  output logic [IDXW-1:0]      snp_idx,
  input  logic [WAYS*TAGW-1:0] frm_tag,
  input  logic [WAYS-1:0]      frm_valid,
  input  logic [WAYS-1:0]      frm_dirty,
  input  logic [WAYS*32-1:0]   frm_data0,
  input  logic [WAYS*32-1:0]   frm_data1,
  output logic                 upd_en,
  output logic [WAYW-1:0]      upd_way,
  output logic                 upd_valid,
  output logic                 upd_dirty,
  input  logic                 link_valid,
  input  logic [31:0]          link_addr,
  output logic                 link_clr
);

  typedef enum logic [1:0] {IDLE, RESP, FLUSH1} state_t;

  state_t          state;
  logic            hit_r;
  logic            dirty_r;
  logic [WAYW-1:0] way_r;
  logic [28:0]     blk_r;

  logic            hit_c;
  logic [WAYW-1:0] way_c;
  logic [TAGW-1:0] snp_tag;
  logic            link_match;
  logic            unused_addr_bits;

  assign snp_idx      = ccsnoopaddr[3 +: IDXW];
  assign snp_tag      = ccsnoopaddr[31 -: TAGW];
  assign snoop_active = ccwait | (state != IDLE);
  assign upd_way      = way_r;
  assign link_match   = link_valid && (link_addr[31:3] == blk_r);
  assign unused_addr_bits = ^{ccsnoopaddr[2:0], link_addr[2:0]};

  // Scan downward so the lowest matching way wins when several ways alias.
  always_comb begin
    hit_c = 1'b0;
    way_c = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (frm_valid[w] && (frm_tag[w*TAGW +: TAGW] == snp_tag)) begin
        hit_c = 1'b1;
        way_c = WAYW'(w);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      hit_r   <= 1'b0;
      dirty_r <= 1'b0;
      way_r   <= '0;
      blk_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            hit_r   <= hit_c;
            dirty_r <= frm_dirty[way_c];
            way_r   <= way_c;
            blk_r   <= ccsnoopaddr[31:3];
            state   <= RESP;
          end
        end
        RESP: begin
          if (hit_r && dirty_r) begin
            if (!dwait) state <= FLUSH1;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH1: begin
          if (!dwait) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state so they hold steady for any length of dwait stall;
  // frame/link strobes are suppressed while reset is asserted so a reset mid-flush leaves the frame alone.
  always_comb begin
    ccwrite      = 1'b0;
    snoop_dstore = '0;
    upd_en       = 1'b0;
    upd_valid    = 1'b0;
    upd_dirty    = 1'b0;
    link_clr     = 1'b0;
    case (state)
      RESP: begin
        if (hit_r && dirty_r) begin
          ccwrite      = 1'b1;
          snoop_dstore = frm_data0[{way_r, 5'b0} +: 32];
        end else if (ccinv) begin
          upd_en   = hit_r;
          link_clr = link_match;
        end
      end
      FLUSH1: begin
        ccwrite      = 1'b1;
        snoop_dstore = frm_data1[{way_r, 5'b0} +: 32];
        if (!dwait) begin
          upd_en    = 1'b1;
          upd_valid = !ccinv;
          link_clr  = ccinv && link_match;
        end
      end
      default: ;
    endcase
    if (!nRST) begin
      upd_en   = 1'b0;
      link_clr = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: fixed vector table for the directed corner cases, then
// random snoop transactions checked against a transaction-level MSI model of the frame array.
module tb_dcache_snoop_responder;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int IDXW = 3;
  localparam int WAYW = 1;
  localparam int TAGW = 26;

  logic                 CLK;
  logic                 nRST;
  logic                 ccwait;
  logic                 ccinv;
  logic [31:0]          ccsnoopaddr;
  logic                 dwait;
  logic                 ccwrite;
  logic [31:0]          snoop_dstore;
  logic                 snoop_active;
  logic [IDXW-1:0]      snp_idx;
  logic [WAYS*TAGW-1:0] frm_tag;
  logic [WAYS-1:0]      frm_valid;
  logic [WAYS-1:0]      frm_dirty;
  logic [WAYS*32-1:0]   frm_data0;
  logic [WAYS*32-1:0]   frm_data1;
  logic                 upd_en;
  logic [WAYW-1:0]      upd_way;
  logic                 upd_valid;
  logic                 upd_dirty;
  logic                 link_valid;
  logic [31:0]          link_addr;
  logic                 link_clr;

  dcache_snoop_responder #(.SETS(SETS), .WAYS(WAYS)) dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .ccwrite(ccwrite), .snoop_dstore(snoop_dstore), .snoop_active(snoop_active),
    .snp_idx(snp_idx), .frm_tag(frm_tag), .frm_valid(frm_valid), .frm_dirty(frm_dirty),
    .frm_data0(frm_data0), .frm_data1(frm_data1), .upd_en(upd_en), .upd_way(upd_way),
    .upd_valid(upd_valid), .upd_dirty(upd_dirty), .link_valid(link_valid),
    .link_addr(link_addr), .link_clr(link_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural frame array: the bench plays the dcache frame and presents the snooped set.
  logic [TAGW-1:0] m_tag   [SETS][WAYS];
  logic            m_valid [SETS][WAYS];
  logic            m_dirty [SETS][WAYS];
  logic [31:0]     m_d0    [SETS][WAYS];
  logic [31:0]     m_d1    [SETS][WAYS];
  logic [IDXW-1:0] bidx;

  assign bidx = ccsnoopaddr[3 +: IDXW];

  always_comb begin
    frm_tag   = '0;
    frm_valid = '0;
    frm_dirty = '0;
    frm_data0 = '0;
    frm_data1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      frm_tag[w*TAGW +: TAGW] = m_tag[bidx][w];
      frm_valid[w]            = m_valid[bidx][w];
      frm_dirty[w]            = m_dirty[bidx][w];
      frm_data0[w*32 +: 32]   = m_d0[bidx][w];
      frm_data1[w*32 +: 32]   = m_d1[bidx][w];
    end
  end

  typedef struct {
    logic            rst_n, ccwait, ccinv, dwait;
    logic [31:0]     addr;
    logic            link_valid;
    logic [31:0]     link_addr;
    logic            ccwrite;
    logic [31:0]     dstore;
    logic            active, upd_en;
    logic [WAYW-1:0] upd_way;
    logic            upd_valid, upd_dirty, link_clr, strict;
  } vec_t;

  int checks = 0;
  int passed = 0;

  function automatic vec_t mk(input logic r, w, i, d, input logic [31:0] a, input logic lv,
                              input logic [31:0] la, input logic cw, input logic [31:0] ds,
                              input logic act, ue, input int uw, input logic uv, ud, lc, st);
    vec_t v;
    v.rst_n = r; v.ccwait = w; v.ccinv = i; v.dwait = d; v.addr = a;
    v.link_valid = lv; v.link_addr = la; v.ccwrite = cw; v.dstore = ds; v.active = act;
    v.upd_en = ue; v.upd_way = WAYW'(uw); v.upd_valid = uv; v.upd_dirty = ud;
    v.link_clr = lc; v.strict = st;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(input logic [TAGW-1:0] tag, input logic [IDXW-1:0] idx,
                                          input logic off);
    return {tag, idx, off, 2'b00};
  endfunction

  task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    nRST        = v.rst_n;
    ccwait      = v.ccwait;
    ccinv       = v.ccinv;
    dwait       = v.dwait;
    ccsnoopaddr = v.addr;
    link_valid  = v.link_valid;
    link_addr   = v.link_addr;
  endtask

  task automatic checkOutput(input vec_t v, input string nm);
    checkField({nm, " ccwrite"}, 32'(ccwrite), 32'(v.ccwrite));
    checkField({nm, " snoop_active"}, 32'(snoop_active), 32'(v.active));
    checkField({nm, " upd_en"}, 32'(upd_en), 32'(v.upd_en));
    checkField({nm, " link_clr"}, 32'(link_clr), 32'(v.link_clr));
    checkField({nm, " snp_idx"}, 32'(snp_idx), 32'(v.addr[3 +: IDXW]));
    if (v.ccwrite || v.strict) checkField({nm, " snoop_dstore"}, snoop_dstore, v.dstore);
    if (v.upd_en || v.strict) begin
      checkField({nm, " upd_way"}, 32'(upd_way), 32'(v.upd_way));
      checkField({nm, " upd_valid"}, 32'(upd_valid), 32'(v.upd_valid));
      checkField({nm, " upd_dirty"}, 32'(upd_dirty), 32'(v.upd_dirty));
    end
  endtask

  task automatic runVec(input vec_t v, input string nm);
    applyStimulus(v);
    @(negedge CLK);
    checkOutput(v, nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic clearFrame();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0; m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
        m_d0[s][w] = '0; m_d1[s][w] = '0;
      end
  endtask

  task automatic randomizeSet(input int s);
    for (int w = 0; w < WAYS; w++) begin
      m_tag[s][w]   = TAGW'($urandom_range(0, 3));
      m_valid[s][w] = 1'($urandom_range(0, 1));
      m_dirty[s][w] = 1'($urandom_range(0, 1));
      m_d0[s][w]    = $urandom();
      m_d1[s][w]    = $urandom();
    end
  endtask

  // One random snoop: expected cycles come from the MSI rules applied to the model frame,
  // then the resulting state change is written back into the model.
  task automatic randomTxn(input int n);
    vec_t            q[$];
    int              set, hw, k;
    logic [TAGW-1:0] tag;
    logic [31:0]     a, la;
    logic            lv, lmatch, inv, hit, m;
    set = $urandom_range(0, SETS - 1);
    if ($urandom_range(0, 3) == 0) randomizeSet(set);
    if ($urandom_range(0, 3) != 0) tag = m_tag[set][$urandom_range(0, WAYS - 1)];
    else tag = TAGW'($urandom_range(0, 3));
    a  = addr_of(tag, IDXW'(set), 1'($urandom_range(0, 1)));
    lv = 1'($urandom_range(0, 1));
    la = ($urandom_range(0, 2) != 0) ? {a[31:3], 1'($urandom_range(0, 1)), 2'b00} : $urandom();
    lmatch = lv && (la[31:3] == a[31:3]);
    hit = 1'b0;
    hw  = 0;
    for (int w = 0; w < WAYS && !hit; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1'b1; hw = w; end
    m = hit && m_dirty[set][hw];
    q.push_back(mk(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, lv, la,
                   0, 0, 1, 0, 0, 0, 0, 0, 0));
    inv = 1'($urandom_range(0, 1));
    if (m) begin
      k = $urandom_range(0, 2);
      repeat (k) q.push_back(mk(1, 0, 1'($urandom_range(0, 1)), 1, a, lv, la,
                                1, m_d0[set][hw], 1, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 1'($urandom_range(0, 1)), 0, a, lv, la, 1, m_d0[set][hw], 1, 0, 0, 0, 0, 0, 0));
      k = $urandom_range(0, 2);
      repeat (k) q.push_back(mk(1, 0, 1'($urandom_range(0, 1)), 1, a, lv, la,
                                1, m_d1[set][hw], 1, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, inv, 0, a, lv, la, 1, m_d1[set][hw], 1, 1, hw, !inv, 0, inv && lmatch, 0));
    end else begin
      q.push_back(mk(1, 0, inv, 1'($urandom_range(0, 1)), a, lv, la,
                     0, 0, 1, hit && inv, hw, 0, 0, inv && lmatch, 0));
    end
    q.push_back(mk(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, lv, la,
                   0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) runVec(q[i], $sformatf("rnd%0d.%0d", n, i));
    if (m) begin
      m_valid[set][hw] = !inv;
      m_dirty[set][hw] = 1'b0;
    end else if (hit && inv) begin
      m_valid[set][hw] = 1'b0;
      m_dirty[set][hw] = 1'b0;
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] a1, a3, a4;
    clearFrame();
    // Set 3: way0 S (other tag), way1 M. Set 5: way0 S. Set 6: two valid ways, neither matches.
    m_tag[3][0] = 26'h0A; m_valid[3][0] = 1; m_dirty[3][0] = 0;
    m_tag[3][1] = 26'h1B; m_valid[3][1] = 1; m_dirty[3][1] = 1;
    m_d0[3][1] = 32'hAAAA0000; m_d1[3][1] = 32'hBBBB0004;
    m_d0[3][0] = 32'h11110000; m_d1[3][0] = 32'h22220004;
    m_tag[5][0] = 26'h2C; m_valid[5][0] = 1; m_dirty[5][0] = 0;
    m_tag[5][1] = 26'h4F; m_valid[5][1] = 0; m_dirty[5][1] = 1;
    m_tag[6][0] = 26'h3D; m_valid[6][0] = 1;
    m_tag[6][1] = 26'h3E; m_valid[6][1] = 1; m_dirty[6][1] = 1;
    a1 = addr_of(26'h1B, 3'd3, 1'b0);
    a3 = addr_of(26'h2C, 3'd5, 1'b0);
    a4 = addr_of(26'h3F, 3'd6, 1'b0);

    // reset
    vecs.push_back(mk(0, 0, 0, 1, a1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // read snoop of M block, one stall cycle per word, M->S
    vecs.push_back(mk(1, 1, 0, 1, a1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a1, 0, 0, 1, 32'hAAAA0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, a1, 0, 0, 1, 32'hAAAA0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a1, 0, 0, 1, 32'hBBBB0004, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, a1, 0, 0, 1, 32'hBBBB0004, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // M block invalidated during FLUSH1 with matching link (word offset differs)
    vecs.push_back(mk(1, 1, 0, 1, a1, 1, a1 | 32'h4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, a1, 1, a1 | 32'h4, 1, 32'hAAAA0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, a1, 1, a1 | 32'h4, 1, 32'hBBBB0004, 1, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, a1, 1, a1 | 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // S hit way0 invalidated
    vecs.push_back(mk(1, 1, 0, 1, a3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, a3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // miss with invalidate
    vecs.push_back(mk(1, 1, 1, 1, a4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, a4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // S hit read snoop: no state change, active exactly two cycles
    vecs.push_back(mk(1, 1, 0, 1, a3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // ccinv without ccwait in IDLE is ignored
    vecs.push_back(mk(1, 0, 1, 0, a3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // reset while stalled in FLUSH1
    vecs.push_back(mk(1, 1, 0, 1, a1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, a1, 0, 0, 1, 32'hAAAA0000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, a1, 0, 0, 1, 32'hBBBB0004, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, a1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    nRST = 0; ccwait = 0; ccinv = 0; dwait = 1; ccsnoopaddr = a1; link_valid = 0; link_addr = 0;
    repeat (2) @(posedge CLK);
    #1;
    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    for (int s = 0; s < SETS; s++) randomizeSet(s);
    for (int n = 0; n < 300; n++) randomTxn(n);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
